// File: rtl/pmf_alu_if.sv
// pmf_alu_if: issue/CDB bundle between a reservation station (master) and
// its integer functional unit (slave).
//   master drives: inEN, op, tagIn, dataIn1, dataIn2, flush, resultAC
//   slave  drives: available, requireCDB, cdbTag, result, overflow
interface pmf_alu_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             inEN;
  logic [2:0]       op;
  logic [TAG_W-1:0] tagIn;
  logic [WIDTH-1:0] dataIn1;
  logic [WIDTH-1:0] dataIn2;
  logic             flush;
  logic             available;
  logic             requireCDB;
  logic             resultAC;
  logic [TAG_W-1:0] cdbTag;
  logic [WIDTH-1:0] result;
  logic             overflow;

  modport master (
    output inEN, op, tagIn, dataIn1, dataIn2, flush, resultAC,
    input  available, requireCDB, cdbTag, result, overflow
  );

  modport slave (
    input  inEN, op, tagIn, dataIn1, dataIn2, flush, resultAC,
    output available, requireCDB, cdbTag, result, overflow
  );
endinterface

// File: rtl/pmf_alu_unit.sv
// pmf_alu_unit: integer functional unit behind one reservation station.
// Takes one tagged op, computes ADD/SUB/AND/OR/XOR/SLT, then holds
// result + tag on its CDB request until granted. A grant may coincide with
// the next issue (zero-bubble back-to-back). flush squashes whatever is in
// flight without broadcasting it.
// Ports:
//   clk   rising-edge clock
//   nRST  asynchronous active-low reset
//   bus   pmf_alu_if.slave (issue side, CDB request/grant, flush)
module pmf_alu_unit #(
  parameter int WIDTH       = 32,
  parameter int TAG_W       = 4,
  parameter bit SUB_TWO_CYC = 1'b1
) (
  input  logic         clk,
  input  logic         nRST,
  pmf_alu_if.slave     bus
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;

  typedef enum logic [1:0] {sIdle, sInverse, sDone} state_t;

  // Latched op; b holds the effective addend once SUB inversion is done.
  typedef struct packed {
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
  } opLatch_t;

  state_t   state;
  opLatch_t lat;
  logic     accept;
  logic     isSub;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] resN;
  logic             ovN;

  assign bus.available = !bus.flush &&
                         (state == sIdle || (state == sDone && bus.resultAC));
  assign accept        = bus.inEN && bus.available;
  assign isSub         = (bus.op == OP_SUB);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state <= sIdle;
      lat   <= '0;
    end else if (bus.flush) begin
      state <= sIdle;
    end else begin
      case (state)
        sIdle, sDone: begin
          if (accept) begin
            lat.op  <= bus.op;
            lat.tag <= bus.tagIn;
            lat.a   <= bus.dataIn1;
            // Single-cycle SUB folds the inversion into the issue edge.
            if (isSub && !SUB_TWO_CYC) begin
              lat.b   <= ~bus.dataIn2;
              lat.cin <= 1'b1;
            end else begin
              lat.b   <= bus.dataIn2;
              lat.cin <= 1'b0;
            end
            state <= (isSub && SUB_TWO_CYC) ? sInverse : sDone;
          end else if (state == sDone && bus.resultAC) begin
            state <= sIdle;
          end
        end
        sInverse: begin
          lat.b   <= ~lat.b;
          lat.cin <= 1'b1;
          state   <= sDone;
        end
        default: state <= sIdle;
      endcase
    end
  end

  // Adder shared by ADD and SUB; SUB arrives here as A + ~B + 1.
  assign sum = lat.a + lat.b + {{(WIDTH-1){1'b0}}, lat.cin};

  always_comb begin
    resN = '0;
    ovN  = 1'b0;
    case (lat.op)
      OP_ADD, OP_SUB: begin
        resN = sum;
        ovN  = (lat.a[WIDTH-1] == lat.b[WIDTH-1]) &&
               (sum[WIDTH-1] != lat.a[WIDTH-1]);
      end
      OP_AND: resN = lat.a & lat.b;
      OP_OR:  resN = lat.a | lat.b;
      OP_XOR: resN = lat.a ^ lat.b;
      OP_SLT: resN = {{(WIDTH-1){1'b0}}, ($signed(lat.a) < $signed(lat.b))};
      default: begin
        resN = '0;
        ovN  = 1'b0;
      end
    endcase
  end

  // Outputs are zeroed whenever no request is up.
  assign bus.requireCDB = (state == sDone);
  assign bus.result     = bus.requireCDB ? resN    : '0;
  assign bus.cdbTag     = bus.requireCDB ? lat.tag : '0;
  assign bus.overflow   = bus.requireCDB && ovN;

endmodule

// File: tb/tb_pmf_alu_unit.sv
module tb_pmf_alu_unit;
  logic clk = 1'b0;
  logic nRST;
  int   nCmp = 0;
  int   nErr = 0;

  always #5 clk = ~clk;

  pmf_alu_if #(.WIDTH(32), .TAG_W(4)) b32 ();
  pmf_alu_if #(.WIDTH(8),  .TAG_W(4)) b8  ();

  pmf_alu_unit #(.WIDTH(32), .TAG_W(4), .SUB_TWO_CYC(1'b1)) u32 (
    .clk(clk), .nRST(nRST), .bus(b32));
  pmf_alu_unit #(.WIDTH(8),  .TAG_W(4), .SUB_TWO_CYC(1'b0)) u8 (
    .clk(clk), .nRST(nRST), .bus(b8));

  // Reference: signed arithmetic on wide integers, then wrap to w bits.
  // Returns {overflow, result}.
  function automatic logic [32:0] refAlu(input int w, input logic [2:0] op,
                                         input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s, lo, hi;
    logic [63:0] mask, r;
    logic ov;
    mask = (64'd1 << w) - 64'd1;
    lo   = -(longint'(1) << (w - 1));
    hi   = (longint'(1) << (w - 1)) - 1;
    sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    ov   = 1'b0;
    r    = '0;
    case (op)
      3'd0: begin s = sa + sb; ov = (s < lo) || (s > hi); r = s & mask; end
      3'd1: begin s = sa - sb; ov = (s < lo) || (s > hi); r = s & mask; end
      3'd2: r = {32'd0, a & b};
      3'd3: r = {32'd0, a | b};
      3'd4: r = {32'd0, a ^ b};
      3'd5: r = (sa < sb) ? 64'd1 : 64'd0;
      default: r = '0;
    endcase
    return {ov, r[31:0]};
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 4))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return $urandom_range(0, 3);
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic idleInputs();
    b32.inEN = 0; b32.op = 0; b32.tagIn = 0; b32.dataIn1 = 0; b32.dataIn2 = 0;
    b32.flush = 0; b32.resultAC = 0;
    b8.inEN = 0; b8.op = 0; b8.tagIn = 0; b8.dataIn1 = 0; b8.dataIn2 = 0;
    b8.flush = 0; b8.resultAC = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drive one issue on the 32-bit unit for one edge (assumed available).
  task automatic issue32(input logic [2:0] op, input logic [3:0] tag,
                         input logic [31:0] a, input logic [31:0] b);
    b32.inEN = 1; b32.op = op; b32.tagIn = tag; b32.dataIn1 = a; b32.dataIn2 = b;
    step();
    b32.inEN = 0;
  endtask

  task automatic grant32();
    b32.resultAC = 1;
    step();
    b32.resultAC = 0;
  endtask

  task automatic test_reset();
    nRST = 0;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    nCmp++; if (b32.available !== 1'b1) begin nErr++; $display("FAIL reset_available got %b exp 1", b32.available); end
    nCmp++; if (b32.requireCDB !== 1'b0) begin nErr++; $display("FAIL reset_requireCDB got %b exp 0", b32.requireCDB); end
    nCmp++; if ({b32.result, b32.cdbTag, b32.overflow} !== 37'd0) begin nErr++; $display("FAIL reset_outputs got %h/%h/%b exp 0", b32.result, b32.cdbTag, b32.overflow); end
    nRST = 1;
    step();
    // Asynchronous reset while holding a result.
    issue32(3'd0, 4'd9, 32'd10, 32'd20);
    nCmp++; if (b32.requireCDB !== 1'b1) begin nErr++; $display("FAIL reset_pre_req got %b exp 1", b32.requireCDB); end
    #2 nRST = 0;
    #1;
    nCmp++; if (b32.requireCDB !== 1'b0 || b32.result !== 32'd0 || b32.available !== 1'b1) begin
      nErr++; $display("FAIL reset_async got req=%b res=%h avail=%b exp 0/0/1", b32.requireCDB, b32.result, b32.available);
    end
    step();
    nRST = 1;
    step();
  endtask

  task automatic test_add();
    logic [31:0] r0;
    logic [3:0]  t0;
    issue32(3'd0, 4'd3, 32'd5, 32'd7);
    nCmp++; if (b32.requireCDB !== 1'b1 || b32.result !== 32'd12 || b32.cdbTag !== 4'd3 || b32.overflow !== 1'b0) begin
      nErr++; $display("FAIL add_5_7 got req=%b res=%h tag=%h ov=%b exp 1/0000000c/3/0", b32.requireCDB, b32.result, b32.cdbTag, b32.overflow);
    end
    r0 = b32.result; t0 = b32.cdbTag;
    for (int i = 0; i < 4; i++) begin
      step();
      nCmp++; if (b32.requireCDB !== 1'b1 || b32.result !== 32'd12 || b32.cdbTag !== 4'd3) begin
        nErr++; $display("FAIL add_hold%0d got req=%b res=%h tag=%h exp 1/0000000c/3", i, b32.requireCDB, b32.result, b32.cdbTag);
      end
    end
    grant32();
    nCmp++; if (b32.requireCDB !== 1'b0 || b32.available !== 1'b1 || b32.result !== 32'd0) begin
      nErr++; $display("FAIL add_grant_idle got req=%b avail=%b res=%h exp 0/1/0 (held %h/%h)", b32.requireCDB, b32.available, b32.result, r0, t0);
    end
  endtask

  task automatic test_sub();
    issue32(3'd1, 4'd4, 32'd3, 32'd5);
    nCmp++; if (b32.requireCDB !== 1'b0 || b32.available !== 1'b0) begin
      nErr++; $display("FAIL sub_inverse_cycle got req=%b avail=%b exp 0/0", b32.requireCDB, b32.available);
    end
    step();
    nCmp++; if (b32.requireCDB !== 1'b1 || b32.result !== 32'hFFFF_FFFE || b32.overflow !== 1'b0 || b32.cdbTag !== 4'd4) begin
      nErr++; $display("FAIL sub_3_5 got req=%b res=%h ov=%b tag=%h exp 1/fffffffe/0/4", b32.requireCDB, b32.result, b32.overflow, b32.cdbTag);
    end
    grant32();
    issue32(3'd1, 4'd6, 32'h8000_0000, 32'd1);
    step();
    nCmp++; if (b32.result !== 32'h7FFF_FFFF || b32.overflow !== 1'b1) begin
      nErr++; $display("FAIL sub_min_1 got res=%h ov=%b exp 7fffffff/1", b32.result, b32.overflow);
    end
    grant32();
  endtask

  task automatic test_back_to_back();
    issue32(3'd0, 4'd1, 32'd40, 32'd2);
    b32.resultAC = 1;
    b32.inEN = 1; b32.op = 3'd0; b32.tagIn = 4'd2; b32.dataIn1 = 32'd1; b32.dataIn2 = 32'd1;
    #1;
    nCmp++; if (b32.available !== 1'b1) begin nErr++; $display("FAIL b2b_available got %b exp 1", b32.available); end
    step();
    b32.inEN = 0; b32.resultAC = 0;
    nCmp++; if (b32.requireCDB !== 1'b1 || b32.result !== 32'd2 || b32.cdbTag !== 4'd2) begin
      nErr++; $display("FAIL b2b_next got req=%b res=%h tag=%h exp 1/00000002/2", b32.requireCDB, b32.result, b32.cdbTag);
    end
    grant32();
  endtask

  task automatic test_flush();
    int seen;
    // Flush during the inverse cycle, with a competing issue.
    issue32(3'd1, 4'd7, 32'd9, 32'd4);
    b32.flush = 1; b32.inEN = 1; b32.op = 3'd0; b32.tagIn = 4'd8;
    #1;
    nCmp++; if (b32.available !== 1'b0) begin nErr++; $display("FAIL flush_blocks_avail got %b exp 0", b32.available); end
    step();
    b32.flush = 0; b32.inEN = 0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (b32.requireCDB) seen++;
      step();
    end
    nCmp++; if (seen !== 0) begin nErr++; $display("FAIL flush_inverse got %0d request cycles exp 0", seen); end
    // Flush while holding a result, with grant and issue both present.
    issue32(3'd0, 4'd5, 32'd1, 32'd2);
    b32.flush = 1; b32.inEN = 1; b32.resultAC = 1; b32.tagIn = 4'd11;
    step();
    b32.flush = 0; b32.inEN = 0; b32.resultAC = 0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (b32.requireCDB || b32.result !== 32'd0) seen++;
      step();
    end
    nCmp++; if (seen !== 0 || b32.available !== 1'b1) begin
      nErr++; $display("FAIL flush_done got %0d active cycles avail=%b exp 0/1", seen, b32.available);
    end
  endtask

  task automatic test_slt_illegal();
    issue32(3'd5, 4'd10, 32'hFFFF_FFFF, 32'd0);
    nCmp++; if (b32.result !== 32'd1 || b32.overflow !== 1'b0) begin
      nErr++; $display("FAIL slt_m1_0 got res=%h ov=%b exp 00000001/0", b32.result, b32.overflow);
    end
    grant32();
    issue32(3'd7, 4'd12, 32'h1234, 32'h5678);
    nCmp++; if (b32.requireCDB !== 1'b1 || b32.result !== 32'd0 || b32.cdbTag !== 4'd12 || b32.overflow !== 1'b0) begin
      nErr++; $display("FAIL illegal_op got req=%b res=%h tag=%h ov=%b exp 1/0/c/0", b32.requireCDB, b32.result, b32.cdbTag, b32.overflow);
    end
    grant32();
  endtask

  task automatic test_width8();
    b8.inEN = 1; b8.op = 3'd0; b8.tagIn = 4'd3; b8.dataIn1 = 8'h7F; b8.dataIn2 = 8'h01;
    step();
    b8.inEN = 0;
    nCmp++; if (b8.requireCDB !== 1'b1 || b8.result !== 8'h80 || b8.overflow !== 1'b1) begin
      nErr++; $display("FAIL w8_add_7f_1 got req=%b res=%h ov=%b exp 1/80/1", b8.requireCDB, b8.result, b8.overflow);
    end
    // Single-cycle SUB variant, back-to-back on the grant.
    b8.resultAC = 1; b8.inEN = 1; b8.op = 3'd1; b8.tagIn = 4'd4; b8.dataIn1 = 8'h80; b8.dataIn2 = 8'h01;
    step();
    b8.resultAC = 0; b8.inEN = 0;
    nCmp++; if (b8.requireCDB !== 1'b1 || b8.result !== 8'h7F || b8.overflow !== 1'b1 || b8.cdbTag !== 4'd4) begin
      nErr++; $display("FAIL w8_sub_1cyc got req=%b res=%h ov=%b tag=%h exp 1/7f/1/4", b8.requireCDB, b8.result, b8.overflow, b8.cdbTag);
    end
    b8.resultAC = 1; step(); b8.resultAC = 0;
  endtask

  task automatic test_random();
    logic [2:0]  cOp;
    logic [3:0]  cTag;
    logic [31:0] cA, cB;
    logic [32:0] exp;
    int          lat, expLat;
    bit          pending;
    pending = 0;
    cOp = 0; cTag = 0; cA = 0; cB = 0;
    for (int i = 0; i < 60; i++) begin
      if (!pending) begin
        cOp = 3'($urandom_range(0, 7)); cTag = 4'($urandom); cA = pickOperand(); cB = pickOperand();
        issue32(cOp, cTag, cA, cB);
      end
      lat = 1;
      while (!b32.requireCDB && lat < 4) begin step(); lat++; end
      expLat = (cOp == 3'd1) ? 2 : 1;
      exp = refAlu(32, cOp, cA, cB);
      nCmp++; if (lat !== expLat || b32.requireCDB !== 1'b1) begin
        nErr++; $display("FAIL rnd%0d_latency got %0d req=%b exp %0d op=%0d", i, lat, b32.requireCDB, expLat, cOp);
      end
      nCmp++; if ({b32.overflow, b32.result} !== exp || b32.cdbTag !== cTag) begin
        nErr++; $display("FAIL rnd%0d_value op=%0d a=%h b=%h got ov=%b res=%h tag=%h exp ov=%b res=%h tag=%h",
                         i, cOp, cA, cB, b32.overflow, b32.result, b32.cdbTag, exp[32], exp[31:0], cTag);
      end
      repeat ($urandom_range(0, 2)) step();
      nCmp++; if ({b32.overflow, b32.result} !== exp) begin
        nErr++; $display("FAIL rnd%0d_hold got %h exp %h", i, {b32.overflow, b32.result}, exp);
      end
      b32.resultAC = 1;
      pending = (i < 59) && ($urandom_range(0, 1) == 1);
      if (pending) begin
        cOp = 3'($urandom_range(0, 7)); cTag = 4'($urandom); cA = pickOperand(); cB = pickOperand();
        b32.inEN = 1; b32.op = cOp; b32.tagIn = cTag; b32.dataIn1 = cA; b32.dataIn2 = cB;
      end
      step();
      b32.resultAC = 0; b32.inEN = 0;
      if (!pending) begin
        nCmp++; if (b32.requireCDB !== 1'b0) begin nErr++; $display("FAIL rnd%0d_release got %b exp 0", i, b32.requireCDB); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_flush();
    test_slt_illegal();
    test_width8();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
